// File: rtl/stream_width_down.sv
// Wide-to-narrow stream serializer: splits each wide word into up to RATIO
// narrow beats, LSB slice first, one beat per cycle with no inter-word bubble.
module stream_width_down #(
  parameter  int DATA_WIDTH = 32,
  parameter  int RATIO      = 4,
  localparam int NUM_WIDTH  = $clog2(RATIO) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        w_ready_o,
  input  logic                        w_valid_i,
  input  logic [DATA_WIDTH*RATIO-1:0] w_data_i,
  input  logic [NUM_WIDTH-1:0]        w_num_i,
  output logic                        r_valid_o,
  input  logic                        r_ready_i,
  output logic [DATA_WIDTH-1:0]       r_data_o,
  output logic                        r_last_o
);

  localparam int IDX_W = $clog2(RATIO);

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_e;

  state_e                           state_q, state_d;
  logic [RATIO-1:0][DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [IDX_W-1:0]                 beat_idx_q, beat_idx_d;
  logic [IDX_W-1:0]                 beat_last_q, beat_last_d;
  logic [IDX_W-1:0]                 eff_last;
  logic                             buf_valid, push, pop;

  assign buf_valid = (state_q == HOLD);
  assign r_valid_o = buf_valid;
  assign r_data_o  = buf_data_q[beat_idx_q];
  assign r_last_o  = buf_valid && (beat_idx_q == beat_last_q);
  assign pop       = r_valid_o && r_ready_i;
  // Ready follows the consumer combinationally so the next word loads as the last beat leaves.
  assign w_ready_o = !buf_valid || (pop && r_last_o);
  assign push      = w_valid_i && w_ready_o;

  // Out-of-range beat counts (0 or > RATIO) mean a full word.
  always_comb begin
    if (w_num_i == '0 || w_num_i > NUM_WIDTH'(RATIO)) eff_last = IDX_W'(RATIO - 1);
    else                                              eff_last = IDX_W'(w_num_i - 1'b1);
  end

  always_comb begin
    state_d     = state_q;
    buf_data_d  = buf_data_q;
    beat_idx_d  = beat_idx_q;
    beat_last_d = beat_last_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d     = HOLD;
          buf_data_d  = w_data_i;
          beat_idx_d  = '0;
          beat_last_d = eff_last;
        end
      end
      HOLD: begin
        if (pop && !r_last_o) begin
          beat_idx_d = beat_idx_q + 1'b1;
        end else if (pop && push) begin
          buf_data_d  = w_data_i;
          beat_idx_d  = '0;
          beat_last_d = eff_last;
        end else if (pop) begin
          state_d    = EMPTY;
          beat_idx_d = '0;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      buf_data_q  <= '0;
      beat_idx_q  <= '0;
      beat_last_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_data_q  <= buf_data_d;
      beat_idx_q  <= beat_idx_d;
      beat_last_q <= beat_last_d;
    end
  end

`ifndef SYNTHESIS
  // Beats popped so far in the current word, and the word's effective length.
  logic [NUM_WIDTH-1:0] sva_cnt_q, sva_num_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sva_cnt_q <= '0;
      sva_num_q <= '0;
    end else begin
      if (pop) begin
        assert (r_last_o == ((sva_cnt_q + NUM_WIDTH'(1)) == sva_num_q));
        sva_cnt_q <= r_last_o ? '0 : sva_cnt_q + NUM_WIDTH'(1);
      end
      if (push) sva_num_q <= NUM_WIDTH'(eff_last) + NUM_WIDTH'(1);
    end
  end

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (r_valid_o && !r_ready_i) |=> (r_valid_o && $stable(r_data_o) && $stable(r_last_o)));
`endif

endmodule

// File: tb/tb_stream_width_down.sv
// Bench for stream_width_down: directed scenarios plus a randomized
// valid/ready stress run checked against a beat-queue reference model.
module tb_stream_width_down;
  localparam int DW = 32;
  localparam int R  = 4;
  localparam int NW = 3;
  localparam int WW = DW * R;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          w_ready_o, w_valid_i, r_valid_o, r_ready_i, r_last_o;
  logic [WW-1:0] w_data_i;
  logic [NW-1:0] w_num_i;
  logic [DW-1:0] r_data_o;

  int errors = 0;
  int checks = 0;

  logic          s_rv, s_rl, s_wr;
  logic [DW-1:0] s_rd;

  typedef struct {logic [DW-1:0] d; logic l;} beat_t;

  stream_width_down #(.DATA_WIDTH(DW), .RATIO(R)) dut (
    .clk(clk), .rst_n(rst_n),
    .w_ready_o(w_ready_o), .w_valid_i(w_valid_i), .w_data_i(w_data_i), .w_num_i(w_num_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o), .r_last_o(r_last_o)
  );

  always #5 clk = ~clk;

  // Sample outputs mid-cycle, then advance past the next rising edge.
  task automatic tick();
    @(negedge clk);
    s_rv = r_valid_o; s_rd = r_data_o; s_rl = r_last_o; s_wr = w_ready_o;
    @(posedge clk);
    #1;
  endtask

  function automatic int eff_of(input int n);
    return (n == 0 || n > R) ? R : n;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; w_valid_i = 1'b0; w_data_i = '0; w_num_i = '0; r_ready_i = 1'b0;
    #3;
    checks++; if (r_valid_o !== 1'b0) begin errors++; $display("FAIL reset_r_valid: got %b want 0", r_valid_o); end
    checks++; if (r_last_o !== 1'b0) begin errors++; $display("FAIL reset_r_last: got %b want 0", r_last_o); end
    checks++; if (r_data_o !== '0) begin errors++; $display("FAIL reset_r_data: got %h want 0", r_data_o); end
    checks++; if (w_ready_o !== 1'b1) begin errors++; $display("FAIL reset_w_ready: got %b want 1", w_ready_o); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    tick();
    checks++; if (s_rv !== 1'b0) begin errors++; $display("FAIL reset_idle_valid: got %b want 0", s_rv); end
    checks++; if (s_wr !== 1'b1) begin errors++; $display("FAIL reset_idle_ready: got %b want 1", s_wr); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    w_valid_i = 1'b1; w_data_i = 128'h44444444_33333333_22222222_11111111; w_num_i = 3'd4; r_ready_i = 1'b1;
    tick();
    checks++; if (s_wr !== 1'b1) begin errors++; $display("FAIL basic_push_ready: got %b want 1", s_wr); end
    w_valid_i = 1'b0; w_data_i = '1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (s_rv !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d]: got %b want 1", i, s_rv); end
      checks++; if (s_rd !== exp[i]) begin errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, s_rd, exp[i]); end
      checks++; if (s_rl !== (i == 3)) begin errors++; $display("FAIL basic_last[%0d]: got %b want %b", i, s_rl, i == 3); end
      checks++; if (s_wr !== (i == 3)) begin errors++; $display("FAIL basic_wready[%0d]: got %b want %b", i, s_wr, i == 3); end
    end
    tick();
    checks++; if (s_rv !== 1'b0) begin errors++; $display("FAIL basic_drained: got %b want 0", s_rv); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp [6] = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3,
                               32'hB0B0B0B0, 32'hB1B1B1B1};
    w_valid_i = 1'b1; w_data_i = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0; w_num_i = 3'd4; r_ready_i = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        w_valid_i = 1'b1; w_data_i = 128'hDEADDEAD_BEEFBEEF_B1B1B1B1_B0B0B0B0; w_num_i = 3'd2;
      end else begin
        w_valid_i = 1'b0;
      end
      tick();
      checks++; if (s_rv !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, s_rv); end
      checks++; if (s_rd !== exp[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, s_rd, exp[i]); end
      checks++; if (s_rl !== (i == 3 || i == 5)) begin errors++; $display("FAIL b2b_last[%0d]: got %b want %b", i, s_rl, i == 3 || i == 5); end
      if (i == 3) begin
        checks++; if (s_wr !== 1'b1) begin errors++; $display("FAIL b2b_accept_b: got %b want 1", s_wr); end
      end
    end
    w_valid_i = 1'b0;
    tick();
    checks++; if (s_rv !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", s_rv); end
  endtask

  task automatic test_num_corners();
    int nums [4] = '{0, 5, 1, 7};
    int exps [4] = '{4, 4, 1, 4};
    logic [WW-1:0] wsave;
    int cnt;
    bit done;
    r_ready_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      wsave = {$urandom, $urandom, $urandom, $urandom};
      w_valid_i = 1'b1; w_data_i = wsave; w_num_i = NW'(nums[t]);
      tick();
      checks++; if (s_wr !== 1'b1) begin errors++; $display("FAIL num%0d_push: got %b want 1", nums[t], s_wr); end
      w_valid_i = 1'b0; w_num_i = '0;
      cnt = 0; done = 0;
      for (int c = 0; c < 10 && !done; c++) begin
        tick();
        if (s_rv) begin
          if (cnt < R) begin
            checks++;
            if (s_rd !== wsave[cnt*DW +: DW]) begin
              errors++; $display("FAIL num%0d_data[%0d]: got %h want %h", nums[t], cnt, s_rd, wsave[cnt*DW +: DW]);
            end
          end
          cnt++;
          if (s_rl) done = 1;
        end
      end
      checks++; if (!done || cnt != exps[t]) begin errors++; $display("FAIL num%0d_beats: got %0d (last seen %0d) want %0d", nums[t], cnt, done, exps[t]); end
    end
    tick();
    checks++; if (s_rv !== 1'b0) begin errors++; $display("FAIL num_drained: got %b want 0", s_rv); end
  endtask

  task automatic test_backpressure();
    bit pat [6] = '{1, 0, 0, 1, 0, 1};
    logic [DW-1:0] exp [4] = '{32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3};
    logic [DW-1:0] prev_rd;
    logic prev_rl;
    bit prev_stall = 0;
    int popped = 0;
    w_valid_i = 1'b1; w_data_i = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0; w_num_i = 3'd4; r_ready_i = 1'b0;
    tick();
    w_valid_i = 1'b1; w_data_i = '0; w_num_i = 3'd1;  // a waiting word must not enter early
    for (int c = 0; c < 20 && popped < 4; c++) begin
      r_ready_i = (c < 6) ? pat[c] : 1'b1;
      tick();
      if (prev_stall) begin
        checks++; if (s_rd !== prev_rd || s_rl !== prev_rl) begin errors++; $display("FAIL bp_stable[%0d]: got %h/%b want %h/%b", c, s_rd, s_rl, prev_rd, prev_rl); end
      end
      checks++; if (s_rv !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", c, s_rv); end
      checks++; if (s_rd !== exp[popped]) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", c, s_rd, exp[popped]); end
      checks++; if (s_wr !== (r_ready_i && popped == 3)) begin errors++; $display("FAIL bp_wready[%0d]: got %b want %b", c, s_wr, r_ready_i && popped == 3); end
      prev_stall = s_rv && !r_ready_i; prev_rd = s_rd; prev_rl = s_rl;
      if (s_rv && r_ready_i) popped++;
    end
    checks++; if (popped != 4) begin errors++; $display("FAIL bp_count: got %0d want 4", popped); end
    // The single-beat word queued behind is accepted on the last pop.
    w_valid_i = 1'b0;
    tick();
    checks++; if (s_rv !== 1'b1 || s_rl !== 1'b1 || s_rd !== '0) begin errors++; $display("FAIL bp_next_word: got %b/%b/%h want 1/1/0", s_rv, s_rl, s_rd); end
    tick();
    checks++; if (s_rv !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", s_rv); end
  endtask

  task automatic test_reset_midword();
    w_valid_i = 1'b1; w_data_i = 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0; w_num_i = 3'd4; r_ready_i = 1'b1;
    tick();
    w_valid_i = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (r_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", r_valid_o); end
    checks++; if (r_last_o !== 1'b0) begin errors++; $display("FAIL rstmid_last: got %b want 0", r_last_o); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (w_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_wready: got %b want 1", w_ready_o); end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (s_rv !== 1'b0) begin errors++; $display("FAIL rstmid_residual[%0d]: got %b want 0", c, s_rv); end
    end
  endtask

  task automatic test_random();
    beat_t q[$];
    int    effq[$];
    int    pushed = 0, done_words = 0, beats_in_word = 0, cyc = 0, n, e;
    bit    exp_wr, push, pop;
    beat_t b;
    w_valid_i = 1'b0; r_ready_i = 1'b1;
    while (done_words < 10000 && cyc < 80000) begin
      tick();
      cyc++;
      exp_wr = (q.size() == 0) || (r_ready_i && q.size() == 1);
      checks++; if (s_rv !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, s_rv, q.size() != 0); end
      checks++; if (s_wr !== exp_wr) begin errors++; $display("FAIL rnd_wready@%0d: got %b want %b", cyc, s_wr, exp_wr); end
      if (s_rv && q.size() != 0) begin
        checks++; if (s_rd !== q[0].d) begin errors++; $display("FAIL rnd_data@%0d: got %h want %h", cyc, s_rd, q[0].d); end
        checks++; if (s_rl !== q[0].l) begin errors++; $display("FAIL rnd_last@%0d: got %b want %b", cyc, s_rl, q[0].l); end
      end
      pop  = s_rv && r_ready_i && q.size() != 0;
      push = w_valid_i && s_wr;
      if (pop) begin
        b = q.pop_front();
        beats_in_word++;
        if (b.l) begin
          e = effq.pop_front();
          checks++; if (beats_in_word != e) begin errors++; $display("FAIL rnd_word_beats@%0d: got %0d want %0d", cyc, beats_in_word, e); end
          beats_in_word = 0;
          done_words++;
        end
      end
      if (push) begin
        n = eff_of(int'(w_num_i));
        effq.push_back(n);
        for (int k = 0; k < n; k++) q.push_back('{d: w_data_i[k*DW +: DW], l: (k == n - 1)});
        pushed++;
        w_valid_i = 1'b0;
      end
      if (!w_valid_i) begin
        w_data_i = {$urandom, $urandom, $urandom, $urandom};
        w_num_i  = NW'($urandom_range(0, 7));
        if (pushed < 10000 && $urandom_range(0, 7) != 0) w_valid_i = 1'b1;
      end
      r_ready_i = ($urandom_range(0, 7) != 0);
    end
    checks++; if (done_words != 10000 || q.size() != 0) begin errors++; $display("FAIL rnd_completion: got %0d words (%0d beats left) want 10000 (0)", done_words, q.size()); end
    w_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_num_corners();
    test_backpressure();
    test_reset_midword();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
